i2c_master: RTL and testbench

I2C_MASTER -- requirements
Module: i2c_master

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_master_if.sv | 39 +++
 rtl/i2c_bit_timer.sv | 45 ++++
 rtl/i2c_master.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_master.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK bus levels, address
// width and the device address used by the on-board responder.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_START    = 4'd1,
    ST_ADDR     = 4'd2,
    ST_ADDR_ACK = 4'd3,
    ST_WRITE    = 4'd4,
    ST_WACK     = 4'd5,
    ST_READ     = 4'd6,
    ST_MACK     = 4'd7,
    ST_STOP     = 4'd8
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int I2C_ADDR_W = 7;
  localparam logic [I2C_ADDR_W-1:0] DEV_ADDR = 7'h4A;

endpackage

// File: rtl/i2c_master_if.sv
// Bundle of the i2c_master user-side and bus-side signals.
//   master modport : the i2c_master block's view
//   slave  modport : the user / bus model's view
//
// Handshakes:
//   start/busy  : start is a one-cycle request, accepted only while busy=0;
//                 addr, rw and nbytes are captured in that same cycle.
//   tx_data/tx_ack : tx_data must be valid whenever the block may ask for a
//                 byte; it is consumed on the clock edge ending the cycle in
//                 which tx_ack=1. The user then presents the next byte.
//   rx_data/rx_valid : rx_valid pulses for one cycle with the new byte on
//                 rx_data; there is no back-pressure, rx_data holds until
//                 the next byte completes.
interface i2c_master_if import i2c_pkg::*; ();
  logic                  start;
  logic [I2C_ADDR_W-1:0] addr;
  logic                  rw;
  logic [3:0]            nbytes;
  logic [7:0]            tx_data;
  logic                  tx_ack;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  done;
  logic                  nack;
  logic                  scl_oe;
  logic                  sda_oe;
  logic                  sda_i;

  modport master (
    input  start, addr, rw, nbytes, tx_data, sda_i,
    output tx_ack, rx_data, rx_valid, busy, done, nack, scl_oe, sda_oe
  );

  modport slave (
    output start, addr, rw, nbytes, tx_data, sda_i,
    input  tx_ack, rx_data, rx_valid, busy, done, nack, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_bit_timer.sv
// Bit-cell timer. A quarter counter runs 0..CLK_DIV-1 and advances the
// phase ph 0..3 on each wrap, so one bit cell is 4*CLK_DIV clk1 cycles.
// Ports:
//   clk1, reset : clock, asynchronous active-high reset
//   en          : run when 1; when 0 both counters are held at 0
//   ph          : current quarter of the cell
//   cell_end    : last clk1 cycle of the cell (end of ph3)
//   sample      : last clk1 cycle of ph2 (SCL high, data stable)
module i2c_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk1,
  input  logic       reset,
  input  logic       en,
  output logic [1:0] ph,
  output logic       cell_end,
  output logic       sample
);

  localparam int QW = $clog2(CLK_DIV);

  logic [QW-1:0] q;
  logic          q_wrap;

  assign q_wrap = (q == QW'(CLK_DIV - 1));

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      q  <= '0;
      ph <= 2'd0;
    end else if (!en) begin
      q  <= '0;
      ph <= 2'd0;
    end else if (q_wrap) begin
      q  <= '0;
      ph <= ph + 2'd1;
    end else begin
      q  <= q + QW'(1);
    end
  end

  assign cell_end = en && q_wrap && (ph == 2'd3);
  assign sample   = en && q_wrap && (ph == 2'd2);

endmodule

// File: rtl/i2c_master.sv
// Single-master I2C controller (no clock stretching, no arbitration).
// Ports:
//   clk1, reset : clock, asynchronous active-high reset
//   bus         : i2c_master_if.master (request, byte streams, status,
//                 open-drain SCL/SDA enables, SDA input)
//   dbg_state   : current FSM state
module i2c_master import i2c_pkg::*; #(
  parameter int CLK_DIV = 4
) (
  input  logic                clk1,
  input  logic                reset,
  i2c_master_if.master        bus,
  output i2c_state_t          dbg_state
);

  i2c_state_t state_q, state_d;

  logic [I2C_ADDR_W-1:0] addr_q;
  logic                  rw_q;
  logic [3:0]            rem_q;
  logic [2:0]            bitcnt_q;
  logic [7:0]            shreg_q;
  logic                  ack_q;
  logic                  sda_s1, sda_s2;
  logic [7:0]            rx_data_q;
  logic                  rx_valid_q;
  logic                  nack_q;

  logic [1:0] ph;
  logic       cell_end, sample;

  logic scl_oe, sda_oe, tx_ack, done, accept, last_bit, set_nack;

  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk1     (clk1),
    .reset    (reset),
    .en       (state_q != ST_IDLE),
    .ph       (ph),
    .cell_end (cell_end),
    .sample   (sample)
  );

  assign last_bit = cell_end && (bitcnt_q == 3'd7);

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and bus drive. Data cells hold SCL low in ph0-1 and release
  // it in ph2-3; SDA enables derive from registered state only, so they
  // change exactly at ph0 entry.
  always_comb begin
    state_d  = state_q;
    scl_oe   = 1'b0;
    sda_oe   = 1'b0;
    tx_ack   = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    set_nack = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        sda_oe = ph[1];
        if (cell_end) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        scl_oe = ~ph[1];
        sda_oe = ~shreg_q[7];
        if (last_bit) state_d = ST_ADDR_ACK;
      end
      ST_ADDR_ACK: begin
        scl_oe = ~ph[1];
        if (cell_end) begin
          if (ack_q == I2C_NACK) begin
            set_nack = 1'b1;
            state_d  = ST_STOP;
          end else if (!rw_q) begin
            tx_ack  = 1'b1;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        scl_oe = ~ph[1];
        sda_oe = ~shreg_q[7];
        if (last_bit) state_d = ST_WACK;
      end
      ST_WACK: begin
        scl_oe = ~ph[1];
        if (cell_end) begin
          if (ack_q == I2C_NACK) begin
            set_nack = 1'b1;
            state_d  = ST_STOP;
          end else if (rem_q != 4'd0) begin
            tx_ack  = 1'b1;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_STOP;
          end
        end
      end
      ST_READ: begin
        scl_oe = ~ph[1];
        if (last_bit) state_d = ST_MACK;
      end
      ST_MACK: begin
        // ACK keeps the slave sending; NACK on the final byte lets it
        // release SDA before STOP.
        scl_oe = ~ph[1];
        sda_oe = (rem_q != 4'd0);
        if (cell_end) state_d = (rem_q != 4'd0) ? ST_READ : ST_STOP;
      end
      ST_STOP: begin
        scl_oe = (ph == 2'd0);
        sda_oe = ~ph[1];
        if (cell_end) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      rw_q       <= 1'b0;
      rem_q      <= 4'd0;
      bitcnt_q   <= 3'd0;
      shreg_q    <= 8'd0;
      ack_q      <= 1'b0;
      sda_s1     <= 1'b0;
      sda_s2     <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      sda_s1     <= bus.sda_i;
      sda_s2     <= sda_s1;
      rx_valid_q <= 1'b0;

      if (accept) begin
        addr_q <= bus.addr;
        rw_q   <= bus.rw;
        rem_q  <= (bus.nbytes == 4'd0) ? 4'd1 : bus.nbytes;
        nack_q <= 1'b0;
      end

      if (set_nack) nack_q <= 1'b1;

      if (tx_ack) shreg_q <= bus.tx_data;

      unique case (state_q)
        ST_START: begin
          if (cell_end) shreg_q <= {addr_q, rw_q};
        end
        ST_ADDR, ST_WRITE: begin
          if (cell_end) begin
            shreg_q  <= {shreg_q[6:0], 1'b0};
            bitcnt_q <= bitcnt_q + 3'd1;
            // Remaining count drops as the byte leaves, i.e. at WACK entry.
            if (state_q == ST_WRITE && bitcnt_q == 3'd7) rem_q <= rem_q - 4'd1;
          end
        end
        ST_ADDR_ACK, ST_WACK: begin
          if (sample) ack_q <= sda_s2;
        end
        ST_READ: begin
          if (sample) begin
            shreg_q <= {shreg_q[6:0], sda_s2};
            if (bitcnt_q == 3'd7) begin
              rx_data_q  <= {shreg_q[6:0], sda_s2};
              rx_valid_q <= 1'b1;
            end
          end
          if (cell_end) begin
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) rem_q <= rem_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.scl_oe   = scl_oe;
  assign bus.sda_oe   = sda_oe;
  assign bus.tx_ack   = tx_ack;
  assign bus.done     = done;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.nack     = nack_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_i2c_master.sv
`timescale 1ns/1ps
module tb_i2c_master;
  import i2c_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk1 = 1'b0;
  logic reset = 1'b1;
  always #5 clk1 = ~clk1;

  i2c_master_if bus_if ();
  i2c_state_t   dbg_state;
  logic         slave_sda = 1'b1;

  i2c_master #(.CLK_DIV(4)) dut (
    .clk1      (clk1),
    .reset     (reset),
    .bus       (bus_if.master),
    .dbg_state (dbg_state)
  );

  // Open-drain SDA: low if either side pulls it.
  assign bus_if.sda_i = !bus_if.sda_oe && slave_sda;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- scoreboard storage ----------------
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic [7:0] exp_rx[$];
  logic [7:0] got_rx[$];
  logic [7:0] wr_bytes[16];
  logic [7:0] rd_bytes[16];
  int         nack_at = -1;
  int         n_start = 0;
  int         n_stop = 0;

  // ---------------- bus decoder + responder ----------------
  logic       prev_scl = 1'b1, prev_sda = 1'b1, cur_scl, cur_sda;
  logic       in_frame = 1'b0, mon_rw = 1'b0, quiet = 1'b0;
  logic [8:0] shift = '0;
  int         rises = 0, byte_idx = 0, idx = 0;

  always @(negedge clk1) begin
    cur_scl = !bus_if.scl_oe;
    cur_sda = bus_if.sda_i;
    if (reset) begin
      prev_scl = 1'b1; prev_sda = 1'b1; in_frame = 1'b0; rises = 0; slave_sda = 1'b1;
    end else begin
      if (prev_scl && cur_scl && prev_sda && !cur_sda) begin
        n_start++; in_frame = 1'b1; rises = 0; byte_idx = 0; shift = '0; quiet = 1'b0;
      end else if (prev_scl && cur_scl && !prev_sda && cur_sda) begin
        n_stop++; in_frame = 1'b0; slave_sda = 1'b1;
      end else if (in_frame && !prev_scl && cur_scl) begin
        shift = {shift[7:0], cur_sda};
        rises++;
        if (rises % 9 == 0) begin
          got_q.push_back(shift);
          if (byte_idx == 0) mon_rw = shift[1];
          if (shift[0] == I2C_NACK && (byte_idx == 0 || mon_rw)) quiet = 1'b1;
          byte_idx++;
        end
      end else if (in_frame && prev_scl && !cur_scl) begin
        idx = rises % 9;
        slave_sda = 1'b1;
        if (idx == 8) begin
          if (byte_idx == 0)
            slave_sda = (shift[7:1] == DEV_ADDR) ? I2C_ACK : I2C_NACK;
          else if (!mon_rw)
            slave_sda = (byte_idx - 1 == nack_at) ? I2C_NACK : I2C_ACK;
        end else if (byte_idx > 0 && byte_idx <= 16 && mon_rw && !quiet) begin
          slave_sda = rd_bytes[byte_idx-1][7-idx];
        end
      end
      prev_scl = cur_scl;
      prev_sda = cur_sda;
    end
  end

  // ---------------- transaction driver + checker ----------------
  // inject_cyc > 0 pulses a conflicting start request at that cycle.
  task automatic run_txn(input logic [6:0] a, input logic r, input logic [3:0] nb,
                         input int inject_cyc, input string name);
    int n, sent, cyc, done_cyc, k, txc, busy_drop, exp_cells;
    bit tx_pend, addr_ok, any_nack, e_ack;
    exp_q.delete(); got_q.delete(); exp_rx.delete(); got_rx.delete();
    n_start = 0; n_stop = 0;

    // Reference: byte-level transaction outcome.
    n = (nb == 4'd0) ? 1 : int'(nb);
    addr_ok = (a == DEV_ADDR);
    any_nack = !addr_ok;
    sent = 0;
    exp_q.push_back({a, r, addr_ok ? I2C_ACK : I2C_NACK});
    if (addr_ok) begin
      for (int i = 0; i < n; i++) begin
        if (!r) begin
          e_ack = (i == nack_at);
          exp_q.push_back({wr_bytes[i], e_ack ? I2C_NACK : I2C_ACK});
          sent++;
          if (e_ack) begin any_nack = 1'b1; break; end
        end else begin
          exp_q.push_back({rd_bytes[i], (i < n - 1) ? I2C_ACK : I2C_NACK});
          exp_rx.push_back(rd_bytes[i]);
          sent++;
        end
      end
    end
    // START + 8 address + ack + 9 per byte + STOP cells, 16 cycles each.
    exp_cells = 11 + 9 * sent;

    k = 0; txc = 0; tx_pend = 1'b0; busy_drop = 0; done_cyc = 0;
    bus_if.tx_data = wr_bytes[0];
    @(negedge clk1);
    bus_if.start = 1'b1; bus_if.addr = a; bus_if.rw = r; bus_if.nbytes = nb;
    @(negedge clk1);
    bus_if.start = 1'b0;
    cyc = 1;
    tests_run++;
    if (bus_if.busy !== 1'b1 || bus_if.nack !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s accept: busy=%b nack=%b expected busy=1 nack=0", name, bus_if.busy, bus_if.nack);
    end
    while (done_cyc == 0 && cyc < 2000) begin
      if (tx_pend) begin k++; bus_if.tx_data = wr_bytes[k]; tx_pend = 1'b0; end
      if (bus_if.tx_ack) begin txc++; tx_pend = 1'b1; end
      if (bus_if.rx_valid) got_rx.push_back(bus_if.rx_data);
      if (bus_if.done) done_cyc = cyc;
      else if (!bus_if.busy) busy_drop++;
      if (cyc == inject_cyc) begin
        bus_if.start = 1'b1; bus_if.addr = ~a; bus_if.rw = ~r; bus_if.nbytes = nb + 4'd3;
      end else begin
        bus_if.start = 1'b0;
      end
      if (done_cyc == 0) begin @(negedge clk1); cyc++; end
    end
    bus_if.start = 1'b0;

    tests_run++;
    if (done_cyc !== exp_cells * 16) begin
      tests_failed++;
      $display("FAIL %s done_latency: got %0d cycles expected %0d (0 = timeout)", name, done_cyc, exp_cells * 16);
    end
    @(negedge clk1);
    tests_run++;
    if ({bus_if.busy, bus_if.scl_oe, bus_if.sda_oe} !== 3'b000 || busy_drop != 0) begin
      tests_failed++;
      $display("FAIL %s idle_after: busy/scl_oe/sda_oe=%b busy_drops=%0d expected 000 and 0",
               name, {bus_if.busy, bus_if.scl_oe, bus_if.sda_oe}, busy_drop);
    end
    tests_run++;
    if (bus_if.nack !== any_nack) begin
      tests_failed++;
      $display("FAIL %s nack: got %b expected %b", name, bus_if.nack, any_nack);
    end
    tests_run++;
    if (n_start != 1 || n_stop != 1) begin
      tests_failed++;
      $display("FAIL %s start_stop: got %0d starts %0d stops expected 1 and 1", name, n_start, n_stop);
    end
    tests_run++;
    if (txc != (r ? 0 : sent)) begin
      tests_failed++;
      $display("FAIL %s tx_ack_count: got %0d expected %0d", name, txc, r ? 0 : sent);
    end
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL %s frame_count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL %s frame[%0d]: got byte %h ack %b expected byte %h ack %b",
                 name, i, got_q[i][8:1], got_q[i][0], exp_q[i][8:1], exp_q[i][0]);
      end
    end
    tests_run++;
    if (got_rx.size() != exp_rx.size()) begin
      tests_failed++;
      $display("FAIL %s rx_count: got %0d expected %0d", name, got_rx.size(), exp_rx.size());
    end
    for (int i = 0; i < exp_rx.size() && i < got_rx.size(); i++) begin
      tests_run++;
      if (got_rx[i] !== exp_rx[i]) begin
        tests_failed++;
        $display("FAIL %s rx_data[%0d]: got %h expected %h", name, i, got_rx[i], exp_rx[i]);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus_if.start = 1'b0; bus_if.addr = '0; bus_if.rw = 1'b0; bus_if.nbytes = '0; bus_if.tx_data = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk1);
    tests_run++;
    if ({bus_if.busy, bus_if.done, bus_if.nack, bus_if.scl_oe, bus_if.sda_oe,
         bus_if.tx_ack, bus_if.rx_valid} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 0000000", {bus_if.busy, bus_if.done, bus_if.nack,
               bus_if.scl_oe, bus_if.sda_oe, bus_if.tx_ack, bus_if.rx_valid});
    end
    tests_run++;
    if (bus_if.rx_data !== 8'h00 || dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: rx_data=%h state=%0d expected 00 and IDLE", bus_if.rx_data, dbg_state);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk1);
    tests_run++;
    if ({bus_if.busy, bus_if.scl_oe, bus_if.sda_oe} !== 3'b000) begin
      tests_failed++;
      $display("FAIL idle_no_start: busy/scl_oe/sda_oe=%b expected 000", {bus_if.busy, bus_if.scl_oe, bus_if.sda_oe});
    end
  endtask

  task automatic test_write_single();
    wr_bytes[0] = 8'hA5; nack_at = -1;
    run_txn(7'h4A, 1'b0, 4'd1, 0, "write_single");
  endtask

  task automatic test_addr_nack();
    wr_bytes[0] = 8'h11; nack_at = -1;
    run_txn(7'h3C, 1'b0, 4'd1, 0, "addr_nack");
  endtask

  task automatic test_read_two();
    rd_bytes[0] = 8'h5A; rd_bytes[1] = 8'hC3; nack_at = -1;
    run_txn(7'h4A, 1'b1, 4'd2, 0, "read_two");
  endtask

  task automatic test_write_nack();
    for (int i = 0; i < 16; i++) wr_bytes[i] = 8'($urandom_range(0, 255));
    nack_at = 1;
    run_txn(7'h4A, 1'b0, 4'd3, 0, "write_nack");
  endtask

  task automatic test_reset_mid();
    wr_bytes[0] = 8'h3E; nack_at = -1;
    @(negedge clk1);
    bus_if.start = 1'b1; bus_if.addr = DEV_ADDR; bus_if.rw = 1'b0; bus_if.nbytes = 4'd1;
    @(negedge clk1);
    bus_if.start = 1'b0;
    // Cycle 82: address bit 4 (a 0 in 0x94), ph0 -> both lines pulled low.
    repeat (81) @(negedge clk1);
    tests_run++;
    if ({bus_if.busy, bus_if.scl_oe, bus_if.sda_oe} !== 3'b111) begin
      tests_failed++;
      $display("FAIL mid_before_reset: busy/scl_oe/sda_oe=%b expected 111", {bus_if.busy, bus_if.scl_oe, bus_if.sda_oe});
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({bus_if.busy, bus_if.scl_oe, bus_if.sda_oe} !== 3'b000 || dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL mid_reset_async: busy/scl_oe/sda_oe=%b state=%0d expected 000 and IDLE",
               {bus_if.busy, bus_if.scl_oe, bus_if.sda_oe}, dbg_state);
    end
    repeat (2) @(negedge clk1);
    reset = 1'b0;
    repeat (2) @(negedge clk1);
    wr_bytes[0] = 8'hC7;
    run_txn(7'h4A, 1'b0, 4'd1, 0, "after_reset");
  endtask

  task automatic test_busy_ignore();
    for (int i = 0; i < 16; i++) begin
      wr_bytes[i] = 8'($urandom_range(0, 255));
      rd_bytes[i] = 8'($urandom_range(0, 255));
    end
    nack_at = -1;
    run_txn(7'h4A, 1'b0, 4'd2, 40, "busy_ignore_w");
    run_txn(7'h4A, 1'b1, 4'd1, 200, "busy_ignore_r");
  endtask

  task automatic test_random();
    logic [6:0] a;
    logic       r;
    logic [3:0] nb;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) begin
        wr_bytes[i] = 8'($urandom_range(0, 255));
        rd_bytes[i] = 8'($urandom_range(0, 255));
      end
      r  = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : DEV_ADDR;
      nb = 4'($urandom_range(0, 4));
      nack_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_txn(a, r, nb, 0, $sformatf("random%0d", t));
    end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_addr_nack();
    test_read_two();
    test_write_nack();
    test_reset_mid();
    test_busy_ignore();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
